// File: rtl/tx_seg_pkg.sv
// Shared types and widths for the TX payload segment request generator.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_PTR_W
`define PAYLOAD_PTR_W 12
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif

package tx_seg_pkg;

  localparam int FLOW_W = `FLOW_ID_W;
  localparam int PTR_W  = `PAYLOAD_PTR_W;
  localparam int SIZE_W = `MSG_DATA_SIZE_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seg_state_e;

  typedef struct packed {
    logic [FLOW_W-1:0] flowid;
    logic [PTR_W-1:0]  offset;
    logic [SIZE_W-1:0] size;
  } rd_mem_req_struct;

  // Unsigned min of the bytes still to send and the segment cap.
  function automatic logic [SIZE_W-1:0] seg_min(input logic [SIZE_W-1:0] remaining,
                                                input logic [SIZE_W-1:0] mss);
    return (remaining < mss) ? remaining : mss;
  endfunction

endpackage

// File: rtl/tx_seg_credit_cnt.sv
// Credit counter: tracks issued read requests whose last data beat is still pending.
// Latency: count updates on the cycle after a consume/return event.
// Backpressure: none; a return while full is a protocol error and saturates.
module tx_seg_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CREDIT_W        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                consume,
  input  logic                credit_ret,
  output logic [CREDIT_W-1:0] count
);

  localparam logic [CREDIT_W-1:0] MAX_CNT = CREDIT_W'(MAX_OUTSTANDING);

  logic [CREDIT_W-1:0] count_q;
  logic [CREDIT_W-1:0] count_d;

  // Next count: consume and return together cancel; return at full saturates.
  always_comb begin
    count_d = count_q;
    if (consume && !credit_ret) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end else if (credit_ret && !consume) begin
      if (count_q != MAX_CNT) count_d = count_q + 1'b1;
    end
  end

  // Count register, full credits out of reset.
  always_ff @(posedge clk) begin
    if (!rst) count_q <= MAX_CNT;
    else      count_q <= count_d;
  end

  assign count = count_q;

  // A last beat with no outstanding request means the snoop and issue sides disagree.
  credit_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(credit_ret && !consume && (count_q == MAX_CNT)))
    else $error("credit return while counter already full");

endmodule

// File: rtl/tx_payload_seg_req_gen.sv
// Splits send commands into MSS-sized payload read requests, throttled by snooped credits.
// Latency: first request the cycle after command accept; segments back-to-back; done pulse after last handshake.
// Backpressure: cmd_rdy low while issuing; request fields hold while rdy is low or credits are exhausted.
module tx_payload_seg_req_gen
  import tx_seg_pkg::*;
#(
  parameter int MSS_BYTES       = 1460,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CREDIT_W        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_seg_cmd_val,
  input  logic [FLOW_W-1:0]   src_seg_cmd_flowid,
  input  logic [PTR_W-1:0]    src_seg_cmd_offset,
  input  logic [SIZE_W-1:0]   src_seg_cmd_len,
  output logic                seg_src_cmd_rdy,
  output logic                seg_dst_rd_mem_req_val,
  output logic [FLOW_W-1:0]   seg_dst_rd_mem_req_flowid,
  output logic [PTR_W-1:0]    seg_dst_rd_mem_req_offset,
  output logic [SIZE_W-1:0]   seg_dst_rd_mem_req_size,
  input  logic                dst_seg_rd_mem_req_rdy,
  input  logic                snoop_tx_data_val,
  input  logic                snoop_tx_data_rdy,
  input  logic                snoop_tx_data_last,
  output logic                seg_cmd_done_val,
  output logic [FLOW_W-1:0]   seg_cmd_done_flowid,
  output logic [CREDIT_W-1:0] credits_avail
);

  localparam logic [SIZE_W-1:0] MSS_C = SIZE_W'(MSS_BYTES);

  seg_state_e        state_q, state_d;
  logic [FLOW_W-1:0] flowid_q, flowid_d;
  logic [PTR_W-1:0]  offset_q, offset_d;
  logic [SIZE_W-1:0] remaining_q, remaining_d;
  logic              done_val_q, done_val_d;
  logic [FLOW_W-1:0] done_flowid_q, done_flowid_d;

  rd_mem_req_struct  req;
  logic              req_val;
  logic              req_fire;
  logic              credit_ret;

  // Request fields come straight from registers so no rdy reaches any val.
  always_comb begin
    req.flowid = flowid_q;
    req.offset = offset_q;
    req.size   = seg_min(remaining_q, MSS_C);
    req_val    = (state_q == ISSUE) && (credits_avail != '0);
    req_fire   = req_val && dst_seg_rd_mem_req_rdy;
    credit_ret = snoop_tx_data_val && snoop_tx_data_rdy && snoop_tx_data_last;
  end

  // Next-state and datapath: accept in IDLE, walk the buffer in ISSUE.
  always_comb begin
    state_d       = state_q;
    flowid_d      = flowid_q;
    offset_d      = offset_q;
    remaining_d   = remaining_q;
    done_val_d    = 1'b0;
    done_flowid_d = done_flowid_q;
    unique case (state_q)
      IDLE: begin
        if (src_seg_cmd_val) begin
          flowid_d    = src_seg_cmd_flowid;
          offset_d    = src_seg_cmd_offset;
          remaining_d = src_seg_cmd_len;
          if (src_seg_cmd_len == '0) begin
            done_val_d    = 1'b1;
            done_flowid_d = src_seg_cmd_flowid;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_fire) begin
          // Truncation to the pointer width gives the circular-buffer wrap.
          offset_d    = offset_q + PTR_W'(req.size);
          remaining_d = remaining_q - req.size;
          if (remaining_q == req.size) begin
            state_d       = IDLE;
            done_val_d    = 1'b1;
            done_flowid_d = flowid_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      flowid_q      <= '0;
      offset_q      <= '0;
      remaining_q   <= '0;
      done_val_q    <= 1'b0;
      done_flowid_q <= '0;
    end else begin
      state_q       <= state_d;
      flowid_q      <= flowid_d;
      offset_q      <= offset_d;
      remaining_q   <= remaining_d;
      done_val_q    <= done_val_d;
      done_flowid_q <= done_flowid_d;
    end
  end

  tx_seg_credit_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CREDIT_W        (CREDIT_W)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .consume    (req_fire),
    .credit_ret (credit_ret),
    .count      (credits_avail)
  );

  assign seg_src_cmd_rdy           = (state_q == IDLE);
  assign seg_dst_rd_mem_req_val    = req_val;
  assign seg_dst_rd_mem_req_flowid = req.flowid;
  assign seg_dst_rd_mem_req_offset = req.offset;
  assign seg_dst_rd_mem_req_size   = req.size;
  assign seg_cmd_done_val          = done_val_q;
  assign seg_cmd_done_flowid       = done_flowid_q;

endmodule
